// File: rtl/fetch_pkg.sv
// Shared sizing constants and FSM encoding for the instruction-fetch miss path.
package fetch_pkg;
    localparam int OFFSET_SIZE         = 5;
    localparam int INDEX_SIZE          = 8;
    localparam int TAG_SIZE            = 64 - (OFFSET_SIZE + INDEX_SIZE);
    localparam int CACHELINE_SIZE_BITS = (2 ** OFFSET_SIZE) * 8;
    localparam int MEM_BUS_BITS        = 64;
    localparam int BEATS               = CACHELINE_SIZE_BITS / MEM_BUS_BITS;
    localparam int BEAT_CNT_BITS       = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RESP  = 2'd2,
        ST_WRITE = 2'd3
    } fsm_state_t;
endpackage

// File: rtl/fetch_miss_handler.sv
// Instruction-cache miss handler: one active refill plus a single pending miss slot,
// line assembled from memory beats and written back to the fetch unit in one pulse.
module fetch_miss_handler
    import fetch_pkg::*;
#(
    parameter int offsetSize        = OFFSET_SIZE,
    parameter int indexSize         = INDEX_SIZE,
    parameter int tagSize           = 64 - (offsetSize + indexSize),
    parameter int cachelineSizeBits = (2 ** offsetSize) * 8,
    parameter int memBusBits        = MEM_BUS_BITS
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         missValid_i,
    input  logic [tagSize-1:0]           missTag_i,
    input  logic [indexSize-1:0]         missIndex_i,
    input  logic [offsetSize-1:0]        missOffset_i,
    output logic                         busy_o,
    output logic                         missDropped_o,
    output logic                         memReqValid_o,
    input  logic                         memReqReady_i,
    output logic [63:0]                  memReqAddr_o,
    input  logic                         memRespValid_i,
    input  logic [memBusBits-1:0]        memRespData_i,
    output logic [tagSize-1:0]           newTag_o,
    output logic [indexSize-1:0]         newIndex_o,
    output logic [offsetSize-1:0]        newOffset_o,
    output logic [cachelineSizeBits-1:0] newCacheline_o,
    output logic                         cacheUpdateEnable_o
);
    localparam int beats    = cachelineSizeBits / memBusBits;
    localparam int beatBits = (beats > 1) ? $clog2(beats) : 1;
    localparam logic [beatBits-1:0] LAST_BEAT = beatBits'(beats - 1);

    fsm_state_t                   state_reg;
    logic                         act_valid_reg;
    logic [tagSize-1:0]           act_tag_reg;
    logic [indexSize-1:0]         act_index_reg;
    logic [offsetSize-1:0]        act_offset_reg;
    logic                         pend_valid_reg;
    logic [tagSize-1:0]           pend_tag_reg;
    logic [indexSize-1:0]         pend_index_reg;
    logic [offsetSize-1:0]        pend_offset_reg;
    logic [beatBits-1:0]          beat_cnt_reg;
    logic [cachelineSizeBits-1:0] line_reg;
    logic [cachelineSizeBits-1:0] line_next;
    logic                         same_act;
    logic                         same_pend;

    // Line identity is tag+index; the offset only matters for the word being fetched.
    assign same_act  = act_valid_reg  && (missTag_i == act_tag_reg)  && (missIndex_i == act_index_reg);
    assign same_pend = pend_valid_reg && (missTag_i == pend_tag_reg) && (missIndex_i == pend_index_reg);
    assign busy_o    = (state_reg != ST_IDLE) || pend_valid_reg;

    // Beat 0 lands in the most significant slot so the line reads as beats in arrival order.
    always_comb begin
        line_next = line_reg;
        for (int k = 0; k < beats; k++) begin
            if (beat_cnt_reg == beatBits'(k)) begin
                line_next[(beats-k)*memBusBits-1 -: memBusBits] = memRespData_i;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg           <= ST_IDLE;
            act_valid_reg       <= 1'b0;
            act_tag_reg         <= '0;
            act_index_reg       <= '0;
            act_offset_reg      <= '0;
            pend_valid_reg      <= 1'b0;
            pend_tag_reg        <= '0;
            pend_index_reg      <= '0;
            pend_offset_reg     <= '0;
            beat_cnt_reg        <= '0;
            line_reg            <= '0;
            missDropped_o       <= 1'b0;
            memReqValid_o       <= 1'b0;
            memReqAddr_o        <= '0;
            newTag_o            <= '0;
            newIndex_o          <= '0;
            newOffset_o         <= '0;
            newCacheline_o      <= '0;
            cacheUpdateEnable_o <= 1'b0;
        end else begin
            missDropped_o       <= 1'b0;
            cacheUpdateEnable_o <= 1'b0;

            if (missValid_i && (state_reg != ST_IDLE) && !same_act && !same_pend) begin
                if (!pend_valid_reg) begin
                    pend_valid_reg  <= 1'b1;
                    pend_tag_reg    <= missTag_i;
                    pend_index_reg  <= missIndex_i;
                    pend_offset_reg <= missOffset_i;
                end else begin
                    missDropped_o <= 1'b1;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (pend_valid_reg) begin
                        act_valid_reg   <= 1'b1;
                        act_tag_reg     <= pend_tag_reg;
                        act_index_reg   <= pend_index_reg;
                        act_offset_reg  <= pend_offset_reg;
                        memReqValid_o   <= 1'b1;
                        memReqAddr_o    <= {pend_tag_reg, pend_index_reg, offsetSize'(0)};
                        state_reg       <= ST_REQ;
                        // Slot frees as the pending entry goes active; a new distinct miss refills it.
                        pend_valid_reg  <= missValid_i && !same_pend;
                        pend_tag_reg    <= missTag_i;
                        pend_index_reg  <= missIndex_i;
                        pend_offset_reg <= missOffset_i;
                    end else if (missValid_i) begin
                        act_valid_reg  <= 1'b1;
                        act_tag_reg    <= missTag_i;
                        act_index_reg  <= missIndex_i;
                        act_offset_reg <= missOffset_i;
                        memReqValid_o  <= 1'b1;
                        memReqAddr_o   <= {missTag_i, missIndex_i, offsetSize'(0)};
                        state_reg      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (memReqValid_o && memReqReady_i) begin
                        memReqValid_o <= 1'b0;
                        beat_cnt_reg  <= '0;
                        state_reg     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (memRespValid_i) begin
                        line_reg     <= line_next;
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        if (beat_cnt_reg == LAST_BEAT) begin
                            newTag_o            <= act_tag_reg;
                            newIndex_o          <= act_index_reg;
                            newOffset_o         <= act_offset_reg;
                            newCacheline_o      <= line_next;
                            cacheUpdateEnable_o <= 1'b1;
                            state_reg           <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    act_valid_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_miss_handler.sv
// Directed bench for fetch_miss_handler: refill, stall, merge, pending, drop and reset cases.
module tb_fetch_miss_handler;
    localparam int TW = 51;
    localparam int IW = 8;
    localparam int OW = 5;
    localparam int LW = 256;
    localparam int BW = 64;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          missValid_i;
    logic [TW-1:0] missTag_i;
    logic [IW-1:0] missIndex_i;
    logic [OW-1:0] missOffset_i;
    logic          busy_o;
    logic          missDropped_o;
    logic          memReqValid_o;
    logic          memReqReady_i;
    logic [63:0]   memReqAddr_o;
    logic          memRespValid_i;
    logic [BW-1:0] memRespData_i;
    logic [TW-1:0] newTag_o;
    logic [IW-1:0] newIndex_o;
    logic [OW-1:0] newOffset_o;
    logic [LW-1:0] newCacheline_o;
    logic          cacheUpdateEnable_o;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_miss_handler dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .missValid_i(missValid_i), .missTag_i(missTag_i),
        .missIndex_i(missIndex_i), .missOffset_i(missOffset_i),
        .busy_o(busy_o), .missDropped_o(missDropped_o),
        .memReqValid_o(memReqValid_o), .memReqReady_i(memReqReady_i),
        .memReqAddr_o(memReqAddr_o),
        .memRespValid_i(memRespValid_i), .memRespData_i(memRespData_i),
        .newTag_o(newTag_o), .newIndex_o(newIndex_o), .newOffset_o(newOffset_o),
        .newCacheline_o(newCacheline_o), .cacheUpdateEnable_o(cacheUpdateEnable_o)
    );

    always #5 clock_i = ~clock_i;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic miss(input logic [TW-1:0] t, input logic [IW-1:0] i, input logic [OW-1:0] o);
        missValid_i  = 1'b1;
        missTag_i    = t;
        missIndex_i  = i;
        missOffset_i = o;
    endtask

    task automatic beats4(input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                          input logic [BW-1:0] b2, input logic [BW-1:0] b3);
        logic [BW-1:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int k = 0; k < 4; k++) begin
            memRespValid_i = 1'b1;
            memRespData_i  = b[k];
            tick();
        end
        memRespValid_i = 1'b0;
    endtask

    // Waits a bounded number of cycles for a request, then checks its address.
    task automatic expect_req(input string tag, input logic [63:0] addr);
        bit seen = 0;
        for (int c = 0; c < 4 && !seen; c++) begin
            if (memReqValid_o) seen = 1;
            else tick();
        end
        check({tag, "_req_seen"}, LW'(seen), LW'(1));
        check({tag, "_addr"}, LW'(memReqAddr_o), LW'(addr));
    endtask

    initial begin
        reset_i = 1'b0; missValid_i = 1'b0; missTag_i = '0; missIndex_i = '0;
        missOffset_i = '0; memReqReady_i = 1'b1; memRespValid_i = 1'b0; memRespData_i = '0;
        #12;
        check("rst_busy", LW'(busy_o), LW'(0));
        check("rst_reqv", LW'(memReqValid_o), LW'(0));
        check("rst_upd", LW'(cacheUpdateEnable_o), LW'(0));
        check("rst_line", newCacheline_o, LW'(0));
        reset_i = 1'b1;
        tick();

        // Basic refill: address, single pulse, line in beat order, original offset.
        miss(51'h1, 8'h12, 5'h04);
        tick();
        missValid_i = 1'b0;
        check("t1_reqv", LW'(memReqValid_o), LW'(1));
        check("t1_addr", LW'(memReqAddr_o), LW'(64'h2240));
        check("t1_busy", LW'(busy_o), LW'(1));
        tick();
        check("t1_resp_reqv", LW'(memReqValid_o), LW'(0));
        beats4(64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444);
        check("t1_upd", LW'(cacheUpdateEnable_o), LW'(1));
        check("t1_line", newCacheline_o,
              {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444});
        check("t1_tag", LW'(newTag_o), LW'(1));
        check("t1_index", LW'(newIndex_o), LW'(8'h12));
        check("t1_offset", LW'(newOffset_o), LW'(5'h04));
        tick();
        check("t1_upd_off", LW'(cacheUpdateEnable_o), LW'(0));
        check("t1_line_hold", newCacheline_o,
              {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444});
        check("t1_idle_busy", LW'(busy_o), LW'(0));

        // Stray beats in IDLE must not start anything.
        memRespValid_i = 1'b1; memRespData_i = 64'hdeaddeaddeaddead;
        tick(); tick();
        memRespValid_i = 1'b0;
        check("t2_idle_stray_upd", LW'(cacheUpdateEnable_o), LW'(0));
        check("t2_idle_stray_busy", LW'(busy_o), LW'(0));

        // Request held with ready low; stray beats during REQ ignored.
        memReqReady_i = 1'b0;
        miss(51'h2, 8'h03, 5'h00);
        tick();
        missValid_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t2_stall%0d_reqv", c), LW'(memReqValid_o), LW'(1));
            check($sformatf("t2_stall%0d_addr", c), LW'(memReqAddr_o), LW'(64'h4060));
            memRespValid_i = c[0];
            memRespData_i  = 64'hbadbadbadbadbad0;
            tick();
        end
        memRespValid_i = 1'b0;
        memReqReady_i  = 1'b1;
        check("t2_hs_reqv", LW'(memReqValid_o), LW'(1));
        tick();
        check("t2_resp_reqv", LW'(memReqValid_o), LW'(0));
        check("t2_resp_upd", LW'(cacheUpdateEnable_o), LW'(0));
        beats4(64'ha0, 64'ha1, 64'ha2, 64'ha3);
        check("t2_upd", LW'(cacheUpdateEnable_o), LW'(1));
        check("t2_line", newCacheline_o, {64'ha0, 64'ha1, 64'ha2, 64'ha3});
        tick();

        // Same-line miss merges; distinct line B goes pending and is issued after A.
        miss(51'h5, 8'h07, 5'h00);
        tick();
        missValid_i = 1'b0;
        tick();
        miss(51'h5, 8'h07, 5'h08);
        tick();
        check("t3_merge_drop", LW'(missDropped_o), LW'(0));
        miss(51'h6, 8'h09, 5'h02);
        tick();
        missValid_i = 1'b0;
        check("t3_b_drop", LW'(missDropped_o), LW'(0));
        check("t3_busy", LW'(busy_o), LW'(1));
        beats4(64'hb0, 64'hb1, 64'hb2, 64'hb3);
        check("t3_a_upd", LW'(cacheUpdateEnable_o), LW'(1));
        check("t3_a_tag", LW'(newTag_o), LW'(5));
        check("t3_a_offset", LW'(newOffset_o), LW'(0));
        tick();
        check("t3_pend_busy", LW'(busy_o), LW'(1));
        expect_req("t3_b", 64'hc120);
        tick();
        beats4(64'hc0, 64'hc1, 64'hc2, 64'hc3);
        check("t3_b_upd", LW'(cacheUpdateEnable_o), LW'(1));
        check("t3_b_offset", LW'(newOffset_o), LW'(2));
        check("t3_b_line", newCacheline_o, {64'hc0, 64'hc1, 64'hc2, 64'hc3});
        tick();

        // Active A, pending B, distinct C is dropped with a single pulse.
        memReqReady_i = 1'b0;
        miss(51'ha, 8'h01, 5'h00);
        tick();
        miss(51'hb, 8'h02, 5'h00);
        tick();
        check("t4_b_drop", LW'(missDropped_o), LW'(0));
        miss(51'hc, 8'h03, 5'h00);
        tick();
        missValid_i = 1'b0;
        check("t4_c_drop", LW'(missDropped_o), LW'(1));
        tick();
        check("t4_drop_once", LW'(missDropped_o), LW'(0));
        check("t4_a_addr", LW'(memReqAddr_o), LW'(64'h14020));
        memReqReady_i = 1'b1;
        tick();
        beats4(64'hd0, 64'hd1, 64'hd2, 64'hd3);
        check("t4_a_upd", LW'(cacheUpdateEnable_o), LW'(1));
        tick();
        expect_req("t4_b", 64'h16040);
        tick();
        beats4(64'he0, 64'he1, 64'he2, 64'he3);
        check("t4_b_tag", LW'(newTag_o), LW'(51'hb));
        begin
            bit c_req = 0;
            for (int c = 0; c < 6; c++) begin
                tick();
                if (memReqValid_o) c_req = 1;
            end
            check("t4_c_never", LW'(c_req), LW'(0));
            check("t4_idle_busy", LW'(busy_o), LW'(0));
        end

        // Reset after two beats abandons the refill.
        miss(51'hd, 8'h04, 5'h01);
        tick();
        missValid_i = 1'b0;
        tick();
        memRespValid_i = 1'b1; memRespData_i = 64'hf0; tick();
        memRespData_i = 64'hf1; tick();
        memRespValid_i = 1'b0;
        reset_i = 1'b0;
        #1;
        check("t5_rst_upd", LW'(cacheUpdateEnable_o), LW'(0));
        check("t5_rst_busy", LW'(busy_o), LW'(0));
        check("t5_rst_line", newCacheline_o, LW'(0));
        check("t5_rst_tag", LW'(newTag_o), LW'(0));
        #2;
        reset_i = 1'b1;
        memRespValid_i = 1'b1; memRespData_i = 64'hf2;
        tick();
        memRespData_i = 64'hf3;
        tick();
        memRespValid_i = 1'b0;
        check("t5_stray_upd", LW'(cacheUpdateEnable_o), LW'(0));
        check("t5_stray_busy", LW'(busy_o), LW'(0));
        miss(51'he, 8'h05, 5'h03);
        tick();
        missValid_i = 1'b0;
        check("t5_e_addr", LW'(memReqAddr_o), LW'(64'h1c0a0));
        tick();
        beats4(64'h10, 64'h20, 64'h30, 64'h40);
        check("t5_e_upd", LW'(cacheUpdateEnable_o), LW'(1));
        check("t5_e_line", newCacheline_o, {64'h10, 64'h20, 64'h30, 64'h40});
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
